// File: rtl/afbc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : afbc_pkg
//  Purpose  : Shared types and constants for the AFBC tile scheduler.
//             sched_state_t is the scheduler FSM state; MODE_* are the
//             AFBC header mode codes used on the compressor side.
//  Revision : 1.0  initial release
// ============================================================================
package afbc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ISSUE    = 2'd1,
        ST_WAIT_CMP = 2'd2,
        ST_WRITE    = 2'd3
    } sched_state_t;

    localparam logic [7:0] MODE_SOLID = 8'h00;
    localparam logic [7:0] MODE_RAW   = 8'h01;

endpackage
`default_nettype wire

// File: rtl/afbc_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : afbc_rr_arbiter
//  Purpose  : Combinational round-robin pick. Grants the first eligible
//             requester strictly after 'pointer', wrapping around, so the
//             last winner has the lowest priority.
//  Ports    : eligible  - per-requester eligibility
//             pointer   - index of the previous winner
//             grant     - one-hot grant (all zero when nothing eligible)
//             grant_idx - binary index of the grant
//             grant_vld - at least one requester was eligible
//  Revision : 1.0  initial release
// ============================================================================
module afbc_rr_arbiter
    import afbc_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     eligible,
    input  logic [IDX_W-1:0] pointer,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_vld
);

    int idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        idx       = 0;
        // Scan offsets 1..N from the pointer; offset N revisits the pointer
        // itself so a lone requester can win back-to-back.
        for (int k = 1; k <= N; k++) begin
            idx = (int'(pointer) + k) % N;
            if (!grant_vld && eligible[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = IDX_W'(idx);
                grant_vld  = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/afbc_tile_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : afbc_tile_scheduler
//  Purpose  : Shares one AFBC compressor between NUM_CLIENTS tile writers.
//             Grants one block at a time round-robin, drives the compressor
//             blk_*/cmp_* handshakes, forwards the compressed result to the
//             memory write port and pulses per-client completion.
//  Ports    : clk/rst (async, active-high); cfg_enable/cfg_mask/err_clr
//             control; req_* client side; blk_*/cmp_* compressor side;
//             wr_* memory side; done_valid/done_err completion; busy,
//             timeout_err and perf_* status.
//  Revision : 1.0  initial release
// ============================================================================
module afbc_tile_scheduler
    import afbc_pkg::*;
#(
    parameter int NUM_CLIENTS = 4,
    parameter int BLK_W       = 4096,
    parameter int CMP_W       = 1024,
    parameter int ADDR_W      = 40,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cfg_enable,
    input  logic [NUM_CLIENTS-1:0]        cfg_mask,
    input  logic                          err_clr,
    input  logic [NUM_CLIENTS-1:0]        req_valid,
    input  logic [NUM_CLIENTS*BLK_W-1:0]  req_pixels,
    input  logic [NUM_CLIENTS*ADDR_W-1:0] req_addr,
    output logic [NUM_CLIENTS-1:0]        req_ready,
    output logic                          blk_valid,
    output logic [BLK_W-1:0]              blk_pixels,
    input  logic                          blk_ready,
    input  logic                          cmp_valid,
    input  logic [CMP_W-1:0]              cmp_data,
    output logic                          cmp_ready,
    output logic                          wr_valid,
    output logic [ADDR_W-1:0]             wr_addr,
    output logic [CMP_W-1:0]              wr_data,
    input  logic                          wr_ready,
    output logic [NUM_CLIENTS-1:0]        done_valid,
    output logic                          done_err,
    output logic                          busy,
    output logic                          timeout_err,
    output logic [31:0]                   perf_grants,
    output logic [31:0]                   perf_drops
);

    localparam int IDX_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
    localparam int TMR_W = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

    sched_state_t            state_q, state_d;
    logic [IDX_W-1:0]        ptr_q, ptr_d;
    logic [IDX_W-1:0]        client_q, client_d;
    logic [BLK_W-1:0]        pixels_q, pixels_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [CMP_W-1:0]        cmp_data_q, cmp_data_d;
    logic [TMR_W-1:0]        timer_q, timer_d;
    logic                    timeout_err_q, timeout_err_d;
    logic [NUM_CLIENTS-1:0]  done_valid_q, done_valid_d;
    logic                    done_err_q, done_err_d;
    logic [31:0]             grants_q, grants_d;
    logic [31:0]             drops_q, drops_d;

    logic [NUM_CLIENTS-1:0]  eligible;
    logic [NUM_CLIENTS-1:0]  grant_oh;
    logic [IDX_W-1:0]        grant_idx;
    logic                    grant_vld;
    logic [NUM_CLIENTS-1:0]  client_oh;

    assign eligible  = req_valid & cfg_mask & {NUM_CLIENTS{cfg_enable}};
    assign client_oh = NUM_CLIENTS'(1) << client_q;

    afbc_rr_arbiter #(
        .N     (NUM_CLIENTS),
        .IDX_W (IDX_W)
    ) u_arb (
        .eligible  (eligible),
        .pointer   (ptr_q),
        .grant     (grant_oh),
        .grant_idx (grant_idx),
        .grant_vld (grant_vld)
    );

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        client_d      = client_q;
        pixels_d      = pixels_q;
        addr_d        = addr_q;
        cmp_data_d    = cmp_data_q;
        timer_d       = timer_q;
        grants_d      = grants_q;
        drops_d       = drops_q;
        done_valid_d  = '0;
        done_err_d    = 1'b0;
        // A timeout raised below overrides this clear (set wins).
        timeout_err_d = err_clr ? 1'b0 : timeout_err_q;

        // Beats accepted outside WAIT_CMP belong to an abandoned job.
        // In WRITE cmp_ready is low, so nothing is accepted there.
        if (cmp_valid && state_q != ST_WAIT_CMP && state_q != ST_WRITE) begin
            drops_d = drops_q + 32'd1;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (grant_vld) begin
                    client_d = grant_idx;
                    ptr_d    = grant_idx;
                    pixels_d = req_pixels[int'(grant_idx)*BLK_W +: BLK_W];
                    addr_d   = req_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
                    grants_d = grants_q + 32'd1;
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (blk_ready) begin
                    timer_d = '0;
                    state_d = ST_WAIT_CMP;
                end
            end
            ST_WAIT_CMP: begin
                if (cmp_valid) begin
                    cmp_data_d = cmp_data;
                    state_d    = ST_WRITE;
                end else if (timer_q == TMR_LAST) begin
                    timeout_err_d = 1'b1;
                    done_valid_d  = client_oh;
                    done_err_d    = 1'b1;
                    state_d       = ST_IDLE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            ST_WRITE: begin
                if (wr_ready) begin
                    done_valid_d = client_oh;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            ptr_q         <= IDX_W'(NUM_CLIENTS - 1);
            client_q      <= '0;
            pixels_q      <= '0;
            addr_q        <= '0;
            cmp_data_q    <= '0;
            timer_q       <= '0;
            timeout_err_q <= 1'b0;
            done_valid_q  <= '0;
            done_err_q    <= 1'b0;
            grants_q      <= '0;
            drops_q       <= '0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            client_q      <= client_d;
            pixels_q      <= pixels_d;
            addr_q        <= addr_d;
            cmp_data_q    <= cmp_data_d;
            timer_q       <= timer_d;
            timeout_err_q <= timeout_err_d;
            done_valid_q  <= done_valid_d;
            done_err_q    <= done_err_d;
            grants_q      <= grants_d;
            drops_q       <= drops_d;
        end
    end

    // Accept pulse is combinational so the client sees it in the grant cycle.
    assign req_ready   = (state_q == ST_IDLE) ? grant_oh : '0;
    assign blk_valid   = (state_q == ST_ISSUE);
    assign blk_pixels  = pixels_q;
    assign cmp_ready   = (state_q != ST_WRITE);
    assign wr_valid    = (state_q == ST_WRITE);
    assign wr_addr     = addr_q;
    assign wr_data     = cmp_data_q;
    assign done_valid  = done_valid_q;
    assign done_err    = done_err_q;
    assign busy        = (state_q != ST_IDLE);
    assign timeout_err = timeout_err_q;
    assign perf_grants = grants_q;
    assign perf_drops  = drops_q;

endmodule
`default_nettype wire

// File: tb/tb_afbc_tile_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_afbc_tile_scheduler
//  Purpose  : Self-checking bench for afbc_tile_scheduler. The bench plays
//             the tile writers, a stub compressor and the memory port.
//  Revision : 1.0  initial release
// ============================================================================
module tb_afbc_tile_scheduler;

    localparam int N  = 4;
    localparam int BW = 64;
    localparam int CW = 32;
    localparam int AW = 40;
    localparam int TO = 1024;

    logic            clk = 1'b0;
    logic            rst;
    logic            cfg_enable;
    logic [N-1:0]    cfg_mask;
    logic            err_clr;
    logic [N-1:0]    req_valid;
    logic [N*BW-1:0] req_pixels;
    logic [N*AW-1:0] req_addr;
    logic [N-1:0]    req_ready;
    logic            blk_valid;
    logic [BW-1:0]   blk_pixels;
    logic            blk_ready;
    logic            cmp_valid;
    logic [CW-1:0]   cmp_data;
    logic            cmp_ready;
    logic            wr_valid;
    logic [AW-1:0]   wr_addr;
    logic [CW-1:0]   wr_data;
    logic            wr_ready;
    logic [N-1:0]    done_valid;
    logic            done_err;
    logic            busy;
    logic            timeout_err;
    logic [31:0]     perf_grants;
    logic [31:0]     perf_drops;

    afbc_tile_scheduler #(
        .NUM_CLIENTS (N),
        .BLK_W       (BW),
        .CMP_W       (CW),
        .ADDR_W      (AW),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_enable  (cfg_enable),
        .cfg_mask    (cfg_mask),
        .err_clr     (err_clr),
        .req_valid   (req_valid),
        .req_pixels  (req_pixels),
        .req_addr    (req_addr),
        .req_ready   (req_ready),
        .blk_valid   (blk_valid),
        .blk_pixels  (blk_pixels),
        .blk_ready   (blk_ready),
        .cmp_valid   (cmp_valid),
        .cmp_data    (cmp_data),
        .cmp_ready   (cmp_ready),
        .wr_valid    (wr_valid),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_ready    (wr_ready),
        .done_valid  (done_valid),
        .done_err    (done_err),
        .busy        (busy),
        .timeout_err (timeout_err),
        .perf_grants (perf_grants),
        .perf_drops  (perf_drops)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference model state: previous winner, counters, sticky error.
    int          m_last;
    int unsigned m_grants;
    int unsigned m_drops;
    logic        m_terr;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_last   = N - 1;
        m_grants = 0;
        m_drops  = 0;
        m_terr   = 1'b0;
    endtask

    // Round-robin rule: first eligible client after the previous winner.
    function automatic logic [N-1:0] model_pick(input logic [N-1:0] elig);
        for (int k = 1; k <= N; k++) begin
            if (elig[(m_last + k) % N]) return N'(1) << ((m_last + k) % N);
        end
        return '0;
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_ready"},  64'(req_ready),   64'h0);
        chk({tag, "_blk_valid"},  64'(blk_valid),   64'h0);
        chk({tag, "_cmp_ready"},  64'(cmp_ready),   64'h1);
        chk({tag, "_wr_valid"},   64'(wr_valid),    64'h0);
        chk({tag, "_wr_addr"},    64'(wr_addr),     64'h0);
        chk({tag, "_done_valid"}, 64'(done_valid),  64'h0);
        chk({tag, "_busy"},       64'(busy),        64'h0);
        chk({tag, "_timeout"},    64'(timeout_err), 64'h0);
        chk({tag, "_grants"},     64'(perf_grants), 64'h0);
        chk({tag, "_drops"},      64'(perf_drops),  64'h0);
    endtask

    // One complete job. exp_oh is the grant the bench expects; zero means
    // no grant. a2 != 0 pins client 2's address. drop_en clears cfg_enable
    // after the grant while everybody keeps requesting.
    task automatic run_job(input logic [N-1:0] rv, input logic [N-1:0] mask, input logic en,
                           input logic [N-1:0] exp_oh, input logic [AW-1:0] a2,
                           input int d_blk, input int d_cmp, input int d_wr, input logic drop_en);
        logic [BW-1:0] pix [N];
        logic [AW-1:0] adr [N];
        logic [CW-1:0] cd;
        int            g;
        g = -1;
        for (int i = 0; i < N; i++) begin
            pix[i] = {$urandom, $urandom};
            adr[i] = {8'($urandom), $urandom};
            if (exp_oh[i]) g = i;
        end
        if (a2 != '0) adr[2] = a2;
        for (int i = 0; i < N; i++) begin
            req_pixels[i*BW +: BW] = pix[i];
            req_addr[i*AW +: AW]   = adr[i];
        end
        cd         = $urandom;
        req_valid  = rv;
        cfg_mask   = mask;
        cfg_enable = en;
        #1;
        chk("grant_req_ready", 64'(req_ready), 64'(exp_oh));
        step();
        req_valid = '0;
        if (g < 0) begin
            chk("no_grant_busy", 64'(busy), 64'h0);
            return;
        end
        m_last = g;
        m_grants++;
        if (drop_en) begin
            cfg_enable = 1'b0;
            req_valid  = '1;
        end
        chk("issue_blk_valid", 64'(blk_valid), 64'h1);
        chk("issue_req_ready", 64'(req_ready), 64'h0);
        for (int c = 0; c < d_blk; c++) begin
            // Stale result beats while a block is pending must be dropped.
            cmp_valid = ($urandom_range(0, 3) == 0);
            if (cmp_valid) m_drops++;
            step();
        end
        cmp_valid = 1'b0;
        chk("issue_blk_pixels", 64'(blk_pixels), 64'(pix[g]));
        chk("issue_blk_valid_hold", 64'(blk_valid), 64'h1);
        blk_ready = 1'b1;
        step();
        blk_ready = 1'b0;
        chk("wait_blk_valid", 64'(blk_valid), 64'h0);
        repeat (d_cmp) step();
        cmp_valid = 1'b1;
        cmp_data  = cd;
        step();
        cmp_valid = 1'b0;
        cmp_data  = $urandom;
        chk("write_wr_valid", 64'(wr_valid), 64'h1);
        chk("write_cmp_ready", 64'(cmp_ready), 64'h0);
        for (int c = 0; c < d_wr; c++) begin
            req_valid = '1;
            #1;
            chk("hold_wr_addr", 64'(wr_addr), 64'(adr[g]));
            chk("hold_wr_data", 64'(wr_data), 64'(cd));
            chk("hold_no_req_ready", 64'({cmp_ready, wr_valid, req_ready}), 64'h10);
            step();
        end
        req_valid = drop_en ? '1 : '0;
        chk("write_wr_addr", 64'(wr_addr), 64'(adr[g]));
        chk("write_wr_data", 64'(wr_data), 64'(cd));
        wr_ready = 1'b1;
        step();
        wr_ready = 1'b0;
        chk("done_valid", 64'(done_valid), 64'(exp_oh));
        chk("done_err", 64'(done_err), 64'h0);
        chk("done_busy", 64'(busy), 64'h0);
        chk("done_grants", 64'(perf_grants), 64'(m_grants));
        chk("done_drops", 64'(perf_drops), 64'(m_drops));
        chk("done_timeout", 64'(timeout_err), 64'(m_terr));
        step();
        chk("done_pulse_end", 64'(done_valid), 64'h0);
        if (drop_en) begin
            repeat (3) begin
                step();
                chk("disabled_busy", 64'(busy), 64'h0);
                chk("disabled_req_ready", 64'(req_ready), 64'h0);
            end
            req_valid  = '0;
            cfg_enable = 1'b1;
        end
    endtask

    typedef struct {
        logic [N-1:0]  rv;
        logic [N-1:0]  mask;
        logic          en;
        logic [N-1:0]  exp_oh;
        logic [AW-1:0] a2;
    } vec_t;

    vec_t vecs [12];
    logic [N-1:0] fair_order [8];

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [N-1:0] rv, mk, ex;
        logic         en;

        // Expected grants derived by hand from the round-robin rule,
        // starting with the pointer at client 3 after reset.
        vecs[0]  = '{4'b0100, 4'b1111, 1'b1, 4'b0100, 40'h1000};
        vecs[1]  = '{4'b1111, 4'b1111, 1'b1, 4'b1000, 40'h0};
        vecs[2]  = '{4'b1111, 4'b1111, 1'b1, 4'b0001, 40'h0};
        vecs[3]  = '{4'b1111, 4'b1011, 1'b1, 4'b0010, 40'h0};
        vecs[4]  = '{4'b1111, 4'b1011, 1'b1, 4'b1000, 40'h0};
        vecs[5]  = '{4'b1111, 4'b1011, 1'b1, 4'b0001, 40'h0};
        vecs[6]  = '{4'b0110, 4'b1111, 1'b0, 4'b0000, 40'h0};
        vecs[7]  = '{4'b1001, 4'b1111, 1'b1, 4'b1000, 40'h0};
        vecs[8]  = '{4'b0001, 4'b1111, 1'b1, 4'b0001, 40'h0};
        vecs[9]  = '{4'b0001, 4'b1111, 1'b1, 4'b0001, 40'h0};
        vecs[10] = '{4'b0000, 4'b1111, 1'b1, 4'b0000, 40'h0};
        vecs[11] = '{4'b1111, 4'b0000, 1'b1, 4'b0000, 40'h0};
        fair_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                       4'b0001, 4'b0010, 4'b0100, 4'b1000};

        rst        = 1'b1;
        cfg_enable = 1'b1;
        cfg_mask   = '1;
        err_clr    = 1'b0;
        req_valid  = '0;
        req_pixels = '0;
        req_addr   = '0;
        blk_ready  = 1'b0;
        cmp_valid  = 1'b0;
        cmp_data   = '0;
        wr_ready   = 1'b0;
        model_reset();
        step();
        step();
        check_reset_outputs("reset");
        rst = 1'b0;
        step();

        // Table-driven jobs; the first is client 2 at 0x1000 with the
        // result arriving 3 cycles after the block is accepted.
        for (int v = 0; v < 12; v++) begin
            run_job(vecs[v].rv, vecs[v].mask, vecs[v].en, vecs[v].exp_oh, vecs[v].a2,
                    (v == 0) ? 0 : v % 3, (v == 0) ? 2 : v % 4, v % 3, 1'b0);
        end

        // Memory stalls for 50 cycles.
        ex = model_pick(4'b0010);
        run_job(4'b0010, 4'b1111, 1'b1, ex, 40'h0, 1, 1, 50, 1'b0);

        // cfg_enable dropped mid-job: the job completes, nothing new starts.
        ex = model_pick(4'b1111);
        run_job(4'b1111, 4'b1111, 1'b1, ex, 40'h0, 2, 3, 2, 1'b1);

        // Randomized jobs against the model.
        for (int t = 0; t < 40; t++) begin
            rv = 4'($urandom_range(0, 15));
            mk = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'b1111;
            en = ($urandom_range(0, 7) != 0);
            ex = model_pick(rv & mk & {N{en}});
            run_job(rv, mk, en, ex, 40'h0, $urandom_range(0, 4),
                    $urandom_range(0, 20), $urandom_range(0, 6), 1'b0);
        end

        // Compressor never answers: timeout after TO cycles in WAIT_CMP.
        ex          = model_pick(4'b0001);
        req_valid   = 4'b0001;
        cfg_mask    = '1;
        cfg_enable  = 1'b1;
        #1;
        chk("to_req_ready", 64'(req_ready), 64'(ex));
        step();
        req_valid = '0;
        m_grants++;
        blk_ready = 1'b1;
        step();
        blk_ready = 1'b0;
        repeat (TO - 1) step();
        chk("to_busy_before", 64'(busy), 64'h1);
        chk("to_done_before", 64'(done_valid), 64'h0);
        step();
        m_terr = 1'b1;
        chk("to_timeout_err", 64'(timeout_err), 64'h1);
        chk("to_done_valid", 64'(done_valid), 64'(ex));
        chk("to_done_err", 64'(done_err), 64'h1);
        chk("to_busy", 64'(busy), 64'h0);
        chk("to_grants", 64'(perf_grants), 64'(m_grants));
        step();
        chk("to_done_end", 64'(done_valid), 64'h0);
        cmp_valid = 1'b1;
        step();
        cmp_valid = 1'b0;
        m_drops++;
        chk("stale_drops", 64'(perf_drops), 64'(m_drops));
        chk("stale_no_write", 64'(wr_valid), 64'h0);
        chk("stale_timeout_sticky", 64'(timeout_err), 64'h1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        m_terr  = 1'b0;
        chk("err_clr", 64'(timeout_err), 64'h0);

        // Reset while waiting on the compressor.
        req_valid = 4'b0010;
        step();
        req_valid = '0;
        blk_ready = 1'b1;
        step();
        blk_ready = 1'b0;
        step();
        chk("pre_rst_busy", 64'(busy), 64'h1);
        rst = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        step();
        rst = 1'b0;
        model_reset();
        repeat (3) begin
            step();
            chk("post_rst_no_done", 64'(done_valid), 64'h0);
        end

        // Fairness from a fresh reset: all clients requesting.
        for (int j = 0; j < 8; j++) begin
            run_job(4'b1111, 4'b1111, 1'b1, fair_order[j], 40'h0, j % 2, j % 3, j % 2, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
